// File: rtl/eater_program_loader_pkg.sv
// Shared types and constants for the eater serial program loader.
package eater_program_loader_pkg;

    // Number of data bytes in one program image (16x8 RAM).
    localparam int unsigned FRAME_LEN = 16;

    // Frame-level states: waiting for sync, receiving data, waiting for checksum.
    typedef enum logic [1:0] {
        F_IDLE,
        F_DATA,
        F_CHECK
    } frame_state_t;

    // UART receiver states.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // 8-bit wrapping checksum accumulation.
    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/eater_program_loader_uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-FF input synchroniser. Samples mid-bit and
// returns to idle at the stop-bit sample so back-to-back bytes are accepted.
module uart_rx_byte
    import eater_program_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;

    // Synchroniser, edge-detect history and receiver state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    // Bit timing, start validation, LSB-first shifting and stop-bit check.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d        = '0;
                    byte_valid_o = rx_sync_q;
                    frame_err_o  = !rx_sync_q;
                    state_d      = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/eater_program_loader.sv
// Serial program loader: receives a framed 16-byte image over UART, writes it
// into the eater RAM and releases the CPU reset only after a good checksum.
module eater_program_loader
    import eater_program_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter logic [7:0]  SYNC_BYTE    = 8'h55
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       uart_rx_i,
    output logic       ram_we_o,
    output logic [3:0] ram_addr_o,
    output logic [7:0] ram_data_o,
    output logic       cpu_reset_o,
    output logic       load_busy_o,
    output logic       load_done_o,
    output logic       load_error_o
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .rx_i        (uart_rx_i),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .frame_err_o (rx_ferr)
    );

    frame_state_t state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [7:0]   sum_q, sum_d;
    logic         we_q, we_d;
    logic [3:0]   addr_q, addr_d;
    logic [7:0]   data_q, data_d;
    logic         cpu_reset_q, cpu_reset_d;
    logic         done_q, done_d;
    logic         error_q, error_d;

    // Frame state, counters and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= F_IDLE;
            cnt_q       <= '0;
            sum_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Frame sequencing: sync, 16 RAM writes, then checksum verdict.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = 1'b0;
        error_d     = error_q;
        unique case (state_q)
            F_IDLE: begin
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    state_d     = F_DATA;
                    cnt_d       = '0;
                    sum_d       = '0;
                    error_d     = 1'b0;
                    cpu_reset_d = 1'b1;
                end
            end
            F_DATA: begin
                if (rx_ferr) begin
                    error_d     = 1'b1;
                    cpu_reset_d = 1'b1;
                    state_d     = F_IDLE;
                end else if (rx_valid) begin
                    we_d   = 1'b1;
                    addr_d = cnt_q;
                    data_d = rx_byte;
                    sum_d  = sum8(sum_q, rx_byte);
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == 4'(FRAME_LEN - 1)) begin
                        state_d = F_CHECK;
                    end
                end
            end
            F_CHECK: begin
                if (rx_ferr) begin
                    error_d     = 1'b1;
                    cpu_reset_d = 1'b1;
                    state_d     = F_IDLE;
                end else if (rx_valid) begin
                    if (rx_byte == sum_q) begin
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        error_d     = 1'b1;
                        cpu_reset_d = 1'b1;
                    end
                    state_d = F_IDLE;
                end
            end
            default: state_d = F_IDLE;
        endcase
    end

    assign ram_we_o     = we_q;
    assign ram_addr_o   = addr_q;
    assign ram_data_o   = data_q;
    assign cpu_reset_o  = cpu_reset_q;
    assign load_busy_o  = (state_q != F_IDLE);
    assign load_done_o  = done_q;
    assign load_error_o = error_q;

endmodule

// File: tb/tb_eater_program_loader.sv
// Self-checking bench for eater_program_loader with CLKS_PER_BIT=8.
module tb_eater_program_loader;

    localparam int unsigned CPB = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic       error;

    int checks = 0;
    int errors = 0;

    logic [11:0] wr_q[$];
    int          done_cnt = 0;
    int          bv_cnt   = 0;
    int          viol_cnt = 0;
    logic [7:0]  frame_data[16];

    eater_program_loader #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'h55)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .uart_rx_i   (rx),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_data_o  (ram_data),
        .cpu_reset_o (cpu_reset),
        .load_busy_o (busy),
        .load_done_o (done),
        .load_error_o(error)
    );

    always #5 clk = ~clk;

    // Observe writes, done pulses, received bytes and write-while-running events.
    always @(negedge clk) begin
        if (ram_we) wr_q.push_back({ram_addr, ram_data});
        if (done) done_cnt++;
        if (dut.u_rx.byte_valid_o) bv_cnt++;
        if (ram_we && !cpu_reset) viol_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (!stop_ok) repeat (CPB) @(negedge clk);
    endtask

    // Reference checksum: arithmetic sum of the image modulo 256.
    function automatic logic [7:0] model_sum();
        int s = 0;
        for (int i = 0; i < 16; i++) s += int'(frame_data[i]);
        return 8'(s % 256);
    endfunction

    task automatic send_frame(input logic [7:0] ck, input int max_gap);
        send_byte(8'h55, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send_byte(frame_data[i], 1'b1);
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        end
        send_byte(ck, 1'b1);
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu got %b want 1", cpu_reset); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", ram_we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
        checks++; if ({ram_addr, ram_data} !== 12'h000) begin errors++; $display("FAIL reset_addr_data got %h want 000", {ram_addr, ram_data}); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL reset_done got %0d want 0", done_cnt); end
    endtask

    task automatic test_good_frame();
        for (int i = 0; i < 16; i++) frame_data[i] = 8'(i);
        wr_q.delete(); done_cnt = 0;
        send_frame(8'h78, 0);
        checks++; if (wr_q.size() !== 16) begin errors++; $display("FAIL good_nwrites got %0d want 16", wr_q.size()); end
        for (int k = 0; k < 16; k++) begin
            logic [11:0] got;
            got = (k < wr_q.size()) ? wr_q[k] : 12'hxxx;
            checks++;
            if (got !== {4'(k), 8'(k)}) begin errors++; $display("FAIL good_write%0d got %h want %h", k, got, {4'(k), 8'(k)}); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL good_done got %0d want 1", done_cnt); end
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL good_cpu got %b want 0", cpu_reset); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy got %b want 0", busy); end
    endtask

    task automatic test_bad_checksum();
        for (int i = 0; i < 16; i++) frame_data[i] = 8'(i);
        wr_q.delete(); done_cnt = 0;
        send_frame(8'h77, 0);
        checks++; if (wr_q.size() !== 16) begin errors++; $display("FAIL badck_nwrites got %0d want 16", wr_q.size()); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL badck_error got %b want 1", error); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL badck_done got %0d want 0", done_cnt); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL badck_cpu got %b want 1", cpu_reset); end
        // Recovery: error clears as soon as the sync byte arrives.
        done_cnt = 0;
        send_byte(8'h55, 1'b1);
        repeat (2) @(negedge clk);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL recover_error_clear got %b want 0", error); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL recover_busy got %b want 1", busy); end
        for (int i = 0; i < 16; i++) send_byte(frame_data[i], 1'b1);
        send_byte(model_sum(), 1'b1);
        repeat (6) @(negedge clk);
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL recover_done got %0d want 1", done_cnt); end
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL recover_cpu got %b want 0", cpu_reset); end
    endtask

    task automatic test_framing_error();
        wr_q.delete(); done_cnt = 0;
        send_byte(8'h55, 1'b1);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h30 + i), i != 5);
        repeat (6) @(negedge clk);
        checks++; if (wr_q.size() !== 5) begin errors++; $display("FAIL ferr_nwrites got %0d want 5", wr_q.size()); end
        for (int k = 0; k < 5; k++) begin
            logic [11:0] got;
            got = (k < wr_q.size()) ? wr_q[k] : 12'hxxx;
            checks++;
            if (got !== {4'(k), 8'(8'h30 + k)}) begin errors++; $display("FAIL ferr_write%0d got %h want %h", k, got, {4'(k), 8'(8'h30 + k)}); end
        end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL ferr_error got %b want 1", error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy got %b want 0", busy); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL ferr_cpu got %b want 1", cpu_reset); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL ferr_done got %0d want 0", done_cnt); end
    endtask

    task automatic test_glitch();
        int bv0;
        wr_q.delete();
        bv0 = bv_cnt;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (bv_cnt - bv0 !== 0) begin errors++; $display("FAIL glitch_bytes got %0d want 0", bv_cnt - bv0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b want 0", busy); end
        send_byte(8'hA0, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (bv_cnt - bv0 !== 1) begin errors++; $display("FAIL nonsync_bytes got %0d want 1", bv_cnt - bv0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nonsync_busy got %b want 0", busy); end
        checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL nonsync_writes got %0d want 0", wr_q.size()); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL nonsync_error_kept got %b want 1", error); end
    endtask

    task automatic test_reset_mid_frame();
        wr_q.delete(); done_cnt = 0;
        send_byte(8'h55, 1'b1);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1);
        repeat (2) @(negedge clk);
        checks++; if (wr_q.size() !== 8) begin errors++; $display("FAIL midrst_nwrites got %0d want 8", wr_q.size()); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if ({ram_we, ram_addr, ram_data} !== 13'h0) begin errors++; $display("FAIL midrst_ram got %h want 0", {ram_we, ram_addr, ram_data}); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL midrst_cpu got %b want 1", cpu_reset); end
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) frame_data[i] = 8'hFF;
        wr_q.delete(); done_cnt = 0;
        send_frame(8'hF0, 0);
        checks++; if (wr_q.size() !== 16) begin errors++; $display("FAIL ff_nwrites got %0d want 16", wr_q.size()); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ff_done got %0d want 1", done_cnt); end
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL ff_cpu got %b want 0", cpu_reset); end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 6; f++) begin
            logic [7:0] ck;
            bit         good;
            int         bad_writes;
            for (int i = 0; i < 16; i++) frame_data[i] = ($urandom_range(3, 0) == 0) ? 8'h55 : 8'($urandom);
            good = ($urandom_range(1, 0) == 1);
            ck = good ? model_sum() : model_sum() ^ 8'($urandom_range(255, 1));
            wr_q.delete(); done_cnt = 0;
            send_frame(ck, 3);
            bad_writes = 0;
            for (int k = 0; k < 16; k++) begin
                if (k >= wr_q.size() || wr_q[k] !== {4'(k), frame_data[k]}) bad_writes++;
            end
            checks++; if (wr_q.size() !== 16 || bad_writes !== 0) begin errors++; $display("FAIL rand%0d_writes n=%0d badwrites=%0d want n=16 badwrites=0", f, wr_q.size(), bad_writes); end
            checks++; if (done_cnt !== (good ? 1 : 0)) begin errors++; $display("FAIL rand%0d_done got %0d want %0d", f, done_cnt, good ? 1 : 0); end
            checks++; if (cpu_reset !== !good) begin errors++; $display("FAIL rand%0d_cpu got %b want %b", f, cpu_reset, !good); end
            checks++; if (error !== !good) begin errors++; $display("FAIL rand%0d_error got %b want %b", f, error, !good); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_framing_error();
        test_glitch();
        test_reset_mid_frame();
        test_random_frames();
        checks++; if (viol_cnt !== 0) begin errors++; $display("FAIL we_while_running got %0d want 0", viol_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
